// File: rtl/count_pwm.sv
// rtl/count_pwm.sv - PWM generator slaved to an external 4-bit free-running counter
module count_pwm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] cnt,
   input  logic       en,
   input  logic [3:0] duty,
   input  logic       duty_we,
   output logic       pwm,
   output logic       period_end,
   output logic       busy,
   output logic       pend
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] shadow_q, shadow_d;
   logic [3:0] active_q, active_d;
   logic       pend_q, pend_d;
   logic       pwm_q, pwm_d;
   logic       period_end_q, period_end_d;
   logic       busy_q, busy_d;
   logic       wrap;
   logic       running_d;

   // A period boundary is only a genuine 15->0 roll; an upstream counter reset is ignored.
   always_comb begin
      cnt_d = cnt;
      wrap  = (cnt_q == 4'hF) && (cnt == 4'h0);
   end

   // Double-buffered duty: new values wait in the shadow and reach the active copy only at a wrap.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      pend_d   = pend_q;
      if (duty_we) begin
         shadow_d = duty;
      end
      if (wrap) begin
         pend_d = 1'b0;
         if (duty_we) begin
            active_d = duty;
         end else if (pend_q) begin
            active_d = shadow_q;
         end
      end else if (duty_we) begin
         pend_d = 1'b1;
      end
   end

   // Run-control FSM: ARM waits for a period boundary, DRAIN finishes the current period.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (en) state_d = ARM;
         end
         ARM: begin
            if (!en)       state_d = IDLE;
            else if (wrap) state_d = RUN;
         end
         RUN: begin
            if (!en) state_d = DRAIN;
         end
         DRAIN: begin
            if (en)        state_d = RUN;
            else if (wrap) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output terms are computed from the post-edge state and duty so they line up with cnt_q.
   always_comb begin
      running_d    = (state_d == RUN) || (state_d == DRAIN);
      pwm_d        = running_d && (cnt < active_d);
      period_end_d = wrap && ((state_q == RUN) || (state_q == DRAIN));
      busy_d       = (state_d != IDLE);
   end

   // State and output registers; reset clears everything at once, forcing the waveform low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 4'h0;
         shadow_q     <= 4'h0;
         active_q     <= 4'h0;
         pend_q       <= 1'b0;
         pwm_q        <= 1'b0;
         period_end_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pwm_q        <= pwm_d;
         period_end_q <= period_end_d;
         busy_q       <= busy_d;
      end
   end

   assign pwm        = pwm_q;
   assign period_end = period_end_q;
   assign busy       = busy_q;
   assign pend       = pend_q;

endmodule

// File: tb/tb_count_pwm.sv
// tb/tb_count_pwm.sv - self-checking bench for count_pwm
module tb_count_pwm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] cnt;
   logic       en;
   logic [3:0] duty;
   logic       duty_we;
   logic       pwm, period_end, busy, pend;

   always #5 clk = ~clk;

   count_pwm dut (
      .clk(clk), .rst_n(rst_n), .cnt(cnt), .en(en), .duty(duty), .duty_we(duty_we),
      .pwm(pwm), .period_end(period_end), .busy(busy), .pend(pend)
   );

   int checks = 0;
   int errors = 0;
   logic [3:0] obs, expv;

   // reference: mode 0 idle, 1 armed, 2 running, 3 finishing period
   int m_mode, m_prev, m_shadow, m_active;
   bit m_pend, e_pwm, e_pe, e_busy;
   int cs;  // counter value the DUT sampled at the last edge

   task automatic tick();
      bit boundary, was_running;
      int c;
      c = int'(cnt);
      if (!rst_n) begin
         m_mode = 0; m_prev = 0; m_shadow = 0; m_active = 0; m_pend = 0;
         e_pwm = 0; e_pe = 0; e_busy = 0;
      end else begin
         boundary    = (m_prev == 15) && (c == 0);
         was_running = (m_mode >= 2);
         if (boundary) begin
            if (duty_we) m_active = int'(duty);
            else if (m_pend) m_active = m_shadow;
            m_pend = 0;
         end else if (duty_we) begin
            m_pend = 1;
         end
         if (duty_we) m_shadow = int'(duty);
         case (m_mode)
            0: if (en) m_mode = 1;
            1: if (!en) m_mode = 0; else if (boundary) m_mode = 2;
            2: if (!en) m_mode = 3;
            default: if (en) m_mode = 2; else if (boundary) m_mode = 0;
         endcase
         e_pe   = boundary && was_running;
         e_pwm  = (m_mode >= 2) && (c < m_active);
         e_busy = (m_mode != 0);
         m_prev = c;
      end
      cs = c;
      @(posedge clk);
      #1;
      cnt     = cnt + 4'd1;
      duty_we = 1'b0;
   endtask

   task automatic run_to(input int target);
      int n;
      n = 0;
      while (int'(cnt) != target && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (int'(cnt) != target) begin
         errors++;
         $display("FAIL run_to cnt=%0d required=%0d", cnt, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; duty = 4'd0; duty_we = 1'b0; cnt = 4'd0;
      repeat (3) tick();
      checks++; if (pwm !== 1'b0)        begin errors++; $display("FAIL reset_pwm got=%b req=0", pwm); end
      checks++; if (period_end !== 1'b0) begin errors++; $display("FAIL reset_period_end got=%b req=0", period_end); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b req=0", busy); end
      checks++; if (pend !== 1'b0)       begin errors++; $display("FAIL reset_pend got=%b req=0", pend); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      duty = 4'd4; duty_we = 1'b1;
      tick();
      checks++; if (pend !== 1'b1) begin errors++; $display("FAIL basic_pend got=%b req=1", pend); end
      run_to(7);
      en = 1'b1;
      tick();
      checks++;
      if ({busy, pwm} !== 2'b10) begin errors++; $display("FAIL basic_arm busy/pwm got=%b%b req=10", busy, pwm); end
      for (int i = 0; i < 8; i++) begin
         tick();
         obs = {pwm, period_end, busy, pend};
         checks++;
         if (obs !== 4'b0011) begin errors++; $display("FAIL basic_prewrap cs=%0d got=%b req=0011", cs, obs); end
      end
      for (int i = 0; i < 48; i++) begin
         tick();
         obs  = {pwm, period_end, busy, pend};
         expv = {cs < 4, (cs == 0) && (i >= 16), 1'b1, 1'b0};
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL basic_run i=%0d cs=%0d got=%b req=%b", i, cs, obs, expv); end
      end
   endtask

   task automatic test_duty_update();
      run_to(2);
      duty = 4'd12; duty_we = 1'b1;
      tick();
      checks++;
      if ({pwm, pend} !== 2'b11) begin errors++; $display("FAIL update_write pwm/pend got=%b%b req=11", pwm, pend); end
      for (int i = 0; i < 13; i++) begin
         tick();
         obs  = {pwm, period_end, busy, pend};
         expv = {cs < 4, 1'b0, 1'b1, 1'b1};
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL update_old cs=%0d got=%b req=%b", cs, obs, expv); end
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         obs  = {pwm, period_end, busy, pend};
         expv = {cs < 12, i == 0, 1'b1, 1'b0};
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL update_new cs=%0d got=%b req=%b", cs, obs, expv); end
      end
   endtask

   task automatic test_wrap_write();
      run_to(0);
      duty = 4'd9; duty_we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         obs  = {pwm, period_end, busy, pend};
         expv = {cs < 9, i == 0, 1'b1, 1'b0};
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL wrapwrite cs=%0d got=%b req=%b", cs, obs, expv); end
      end
   endtask

   task automatic test_drain();
      run_to(0);
      duty = 4'd10; duty_we = 1'b1;
      tick();
      run_to(6);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         obs  = {pwm, period_end, busy};
         expv = {1'b0, cs < 10, 1'b0, 1'b1};
         checks++;
         if (obs[2:0] !== expv[2:0]) begin errors++; $display("FAIL drain_tail cs=%0d got=%b req=%b", cs, obs[2:0], expv[2:0]); end
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         obs  = {1'b0, pwm, period_end, busy};
         expv = {1'b0, 1'b0, i == 0, 1'b0};
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL drain_end i=%0d got=%b req=%b", i, obs[2:0], expv[2:0]); end
      end
      en = 1'b1;
      run_to(0);
      tick();
      run_to(6);
      en = 1'b0;
      tick();
      run_to(9);
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         obs  = {1'b0, pwm, period_end, busy};
         expv = {1'b0, cs < 10, cs == 0, 1'b1};
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL drain_rejoin cs=%0d got=%b req=%b", cs, obs[2:0], expv[2:0]); end
      end
   endtask

   task automatic test_extremes();
      duty = 4'd0; duty_we = 1'b1;
      tick();
      run_to(0);
      for (int i = 0; i < 33; i++) begin
         tick();
         checks++;
         if ({pwm, busy} !== 2'b01) begin errors++; $display("FAIL duty0 cs=%0d pwm/busy got=%b%b req=01", cs, pwm, busy); end
      end
      duty = 4'd15; duty_we = 1'b1;
      tick();
      run_to(0);
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (pwm !== (cs != 15)) begin errors++; $display("FAIL duty15 cs=%0d pwm got=%b req=%b", cs, pwm, cs != 15); end
      end
   endtask

   task automatic test_counter_reset();
      int n;
      en = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin tick(); n++; end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL cntrst_idle busy got=%b req=0", busy); end
      run_to(5);
      en = 1'b1;
      tick();
      run_to(8);
      cnt = 4'd0;
      tick();
      checks++;
      if ({busy, pwm} !== 2'b10) begin errors++; $display("FAIL cntrst_jump busy/pwm got=%b%b req=10", busy, pwm); end
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if ({busy, pwm} !== 2'b10) begin errors++; $display("FAIL cntrst_arm cs=%0d busy/pwm got=%b%b req=10", cs, busy, pwm); end
      end
      tick();
      checks++;
      if ({pwm, period_end, busy} !== 3'b101) begin errors++; $display("FAIL cntrst_enter got=%b%b%b req=101", pwm, period_end, busy); end
   endtask

   task automatic test_async_reset();
      run_to(4);
      tick();
      checks++;
      if (pwm !== 1'b1) begin errors++; $display("FAIL areset_pre pwm got=%b req=1", pwm); end
      #3 rst_n = 1'b0;
      #1;
      obs = {pwm, period_end, busy, pend};
      checks++;
      if (obs !== 4'b0000) begin errors++; $display("FAIL areset_now got=%b req=0000", obs); end
      tick();
      tick();
      obs = {pwm, period_end, busy, pend};
      checks++;
      if (obs !== 4'b0000) begin errors++; $display("FAIL areset_held got=%b req=0000", obs); end
      rst_n = 1'b1;
      en = 1'b1;
      cnt = 4'd0;
      duty = 4'd15; duty_we = 1'b1;
      tick();
      obs = {pwm, period_end, busy, pend};
      checks++;
      if (obs !== 4'b0011) begin errors++; $display("FAIL areset_nowrap got=%b req=0011", obs); end
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if ({pwm, busy, pend} !== 3'b011) begin errors++; $display("FAIL areset_armed got=%b%b%b req=011", pwm, busy, pend); end
      tick();
      obs = {pwm, period_end, busy, pend};
      checks++;
      if (obs !== 4'b1010) begin errors++; $display("FAIL areset_firstwrap got=%b req=1010", obs); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 11) == 0) en = ~en;
         if ($urandom_range(0, 7) == 0) begin
            duty    = 4'($urandom_range(0, 15));
            duty_we = 1'b1;
         end
         if ($urandom_range(0, 39) == 0) cnt = 4'($urandom_range(0, 15));
         tick();
         obs  = {pwm, period_end, busy, pend};
         expv = {e_pwm, e_pe, e_busy, m_pend};
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL random i=%0d cs=%0d got=%b req=%b", i, cs, obs, expv); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duty_update();
      test_wrap_write();
      test_drain();
      test_extremes();
      test_counter_reset();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
